ts_payload_gen: RTL

TS_PAYLOAD_GEN -- requirements
Module: ts_payload_gen

---
 rtl/ts_payload_gen_pkg.sv | 30 +++
 rtl/ts_payload_gen_if.sv | 34 +++
 rtl/ts_rr_arbiter.sv | 38 +++
 rtl/ts_payload_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/ts_payload_gen_pkg.sv
// ============================================================================
// Module  : ts_payload_gen_pkg
// Brief   : Shared constants, FSM encoding and word builder for the TS payload generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ts_payload_gen_pkg;

    localparam int         c_PKT_WORDS = 47;
    localparam logic [7:0] c_SYNC_BYTE = 8'h47;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SELECT = 2'd1;
    localparam logic [1:0] c_ST_SEND   = 2'd2;
    localparam logic [1:0] c_ST_GAP    = 2'd3;

    // Word 0 carries the sync byte; later words carry the index and its complement.
    function automatic logic [31:0] ts_word(input logic [7:0] idx,
                                            input logic [3:0] cc,
                                            input logic [3:0] chan);
        if (idx == 8'd0)
            ts_word = {c_SYNC_BYTE, 8'h00, cc, 8'h00, chan};
        else
            ts_word = {idx, ~idx, cc, 8'h00, chan};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ts_payload_gen_if.sv
// ============================================================================
// Module  : ts_payload_gen_if
// Brief   : Valid/ready word stream carrying TS packets with start/end framing.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ts_payload_gen_if #(
    parameter int DATA_W = 32
);
    logic              payload_out_valid;
    logic              payload_out_ready;
    logic              payload_out_start;
    logic              payload_out_end;
    logic [DATA_W-1:0] payload_out_data;

    modport master (
        output payload_out_valid,
        output payload_out_start,
        output payload_out_end,
        output payload_out_data,
        input  payload_out_ready
    );

    modport slave (
        input  payload_out_valid,
        input  payload_out_start,
        input  payload_out_end,
        input  payload_out_data,
        output payload_out_ready
    );
endinterface

`default_nettype wire

// File: rtl/ts_rr_arbiter.sv
// ============================================================================
// Module  : ts_rr_arbiter
// Brief   : Combinational round-robin picker; first set mask bit after i_last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ts_rr_arbiter
    import ts_payload_gen_pkg::*;
#(
    parameter int N_CHANS = 16,
    parameter int IDX_W   = 4
) (
    input  wire logic [N_CHANS-1:0] i_mask,
    input  wire logic [IDX_W-1:0]   i_last,
    output logic      [IDX_W-1:0]   o_grant,
    output logic                    o_any
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = N_CHANS; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % N_CHANS);
            if (i_mask[w_cand]) begin
                o_grant = w_cand;
                o_any   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ts_payload_gen.sv
// ============================================================================
// Module  : ts_payload_gen
// Brief   : Round-robin multi-channel TS packet payload generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ts_payload_gen
    import ts_payload_gen_pkg::*;
#(
    parameter int P_OUT_CHANS        = 16,
    parameter int PAYLOAD_DATA_WIDTH = 32,
    parameter int P_PKT_WORDS        = c_PKT_WORDS
) (
    input  wire logic                   payload_clk,
    input  wire logic                   payload_rst_n,
    input  wire logic                   gen_enable,
    input  wire logic [P_OUT_CHANS-1:0] chan_mask,
    input  wire logic [7:0]             gap_cycles,
    ts_payload_gen_if.master            out_if,
    output logic      [31:0]            pkt_count
);

    localparam int c_CH_W  = (P_OUT_CHANS > 1) ? $clog2(P_OUT_CHANS) : 1;
    localparam int c_IDX_W = (P_PKT_WORDS > 1) ? $clog2(P_PKT_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(P_PKT_WORDS - 1);

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_CH_W-1:0]  r_chan;
    logic [7:0]         r_gap;
    logic [31:0]        r_pkt_count;
    logic [3:0]         r_cc [P_OUT_CHANS];

    logic [c_CH_W-1:0]  w_grant;
    logic               w_any;
    logic               w_valid;
    logic               w_xfer;
    logic               w_last_word;
    logic [31:0]        w_word;

    ts_rr_arbiter #(
        .N_CHANS (P_OUT_CHANS),
        .IDX_W   (c_CH_W)
    ) u_arb (
        .i_mask  (chan_mask),
        .i_last  (r_chan),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_valid     = (r_state == c_ST_SEND);
    assign w_xfer      = w_valid && out_if.payload_out_ready;
    assign w_last_word = (r_idx == c_LAST_IDX);
    assign w_word      = ts_word(8'(r_idx), r_cc[r_chan], 4'(r_chan));

    assign out_if.payload_out_valid = w_valid;
    assign out_if.payload_out_start = w_valid && (r_idx == '0);
    assign out_if.payload_out_end   = w_valid && w_last_word;
    assign out_if.payload_out_data  = w_valid ? PAYLOAD_DATA_WIDTH'(w_word) : '0;
    assign pkt_count                = r_pkt_count;

    // r_chan doubles as the last-served pointer for the round-robin search.
    always_ff @(posedge payload_clk) begin
        if (!payload_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_chan      <= c_CH_W'(P_OUT_CHANS - 1);
            r_gap       <= '0;
            r_pkt_count <= '0;
            for (int i = 0; i < P_OUT_CHANS; i++)
                r_cc[i] <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (gen_enable && w_any)
                        r_state <= c_ST_SELECT;
                end
                c_ST_SELECT: begin
                    if (gen_enable && w_any) begin
                        r_chan  <= w_grant;
                        r_idx   <= '0;
                        r_state <= c_ST_SEND;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SEND: begin
                    if (w_xfer) begin
                        if (w_last_word) begin
                            r_idx         <= '0;
                            r_cc[r_chan]  <= r_cc[r_chan] + 4'd1;
                            r_pkt_count   <= r_pkt_count + 32'd1;
                            if (gap_cycles != 8'd0) begin
                                r_gap   <= gap_cycles;
                                r_state <= c_ST_GAP;
                            end else begin
                                r_state <= c_ST_SELECT;
                            end
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                c_ST_GAP: begin
                    r_gap <= r_gap - 8'd1;
                    if (r_gap == 8'd1)
                        r_state <= c_ST_SELECT;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
